// File: rtl/pipe_ctrl.sv
// Central pipeline controller: stall vector generation, flush sequencing,
// stall timeout detection and saturating stall/flush performance counters.
module pipe_ctrl #(
    parameter int NSTAGES      = 5,
    parameter int FLUSH_CYCLES = 1,
    parameter int MAX_STALL    = 1024,
    parameter int CNT_W        = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NSTAGES-1:0] stallreq,
    input  logic               flush_req,
    input  logic [31:0]        flush_pc,
    output logic [NSTAGES:0]   stall,
    output logic               flush,
    output logic [31:0]        new_pc,
    output logic               busy,
    output logic               stall_timeout,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    localparam int FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int RUN_W = $clog2(MAX_STALL);
    localparam logic [FC_W-1:0]  FC_LOAD = FC_W'(FLUSH_CYCLES - 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_STALL - 1);

    typedef enum logic {
        IDLE,
        FLUSH
    } state_t;

    state_t             state_q, state_d;
    logic               flush_q, flush_d;
    logic               busy_q, busy_d;
    logic [31:0]        new_pc_q, new_pc_d;
    logic [FC_W-1:0]    fc_q, fc_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic               acc;
    logic               stall_any;

    // Suffix-OR: the oldest requesting stage holds itself and all younger ones.
    always_comb begin
        stall = '0;
        acc   = 1'b0;
        if (state_q == IDLE) begin
            for (int k = NSTAGES - 1; k >= 0; k--) begin
                acc = acc | stallreq[k];
                stall[k+1] = acc;
            end
            stall[0] = acc;
        end
    end

    assign stall_any = |stall;

    always_comb begin
        state_d     = state_q;
        flush_d     = flush_q;
        busy_d      = busy_q;
        new_pc_d    = new_pc_q;
        fc_d        = fc_q;
        flush_cnt_d = flush_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (flush_req) begin
                    state_d  = FLUSH;
                    flush_d  = 1'b1;
                    busy_d   = 1'b1;
                    new_pc_d = flush_pc;
                    fc_d     = FC_LOAD;
                    if (!(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
                end
            end
            FLUSH: begin
                if (fc_q == '0) begin
                    state_d = IDLE;
                    flush_d = 1'b0;
                    busy_d  = 1'b0;
                end else begin
                    fc_d = fc_q - FC_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        run_d       = '0;
        timeout_d   = timeout_q;
        stall_cnt_d = stall_cnt_q;
        if (stall_any) begin
            run_d = (run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1);
            if (run_q == RUN_MAX) timeout_d = 1'b1;
            if (!(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            flush_q     <= 1'b0;
            busy_q      <= 1'b0;
            new_pc_q    <= '0;
            fc_q        <= '0;
            run_q       <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_q     <= flush_d;
            busy_q      <= busy_d;
            new_pc_q    <= new_pc_d;
            fc_q        <= fc_d;
            run_q       <= run_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign flush         = flush_q;
    assign busy          = busy_q;
    assign new_pc        = new_pc_q;
    assign stall_timeout = timeout_q;
    assign stall_cnt     = stall_cnt_q;
    assign flush_cnt     = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: instance a has FLUSH_CYCLES=3, instance b
// has FLUSH_CYCLES=1; both use MAX_STALL=8 and CNT_W=4 and share inputs.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  stallreq;
    logic        flush_req;
    logic [31:0] flush_pc;

    logic [5:0]  a_stall, b_stall;
    logic        a_flush, b_flush, a_busy, b_busy, a_to, b_to;
    logic [31:0] a_pc, b_pc;
    logic [3:0]  a_scnt, b_scnt, a_fcnt, b_fcnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.NSTAGES(5), .FLUSH_CYCLES(3), .MAX_STALL(8), .CNT_W(4)) u_a (
        .clk(clk), .rst(rst), .stallreq(stallreq), .flush_req(flush_req),
        .flush_pc(flush_pc), .stall(a_stall), .flush(a_flush), .new_pc(a_pc),
        .busy(a_busy), .stall_timeout(a_to), .stall_cnt(a_scnt),
        .flush_cnt(a_fcnt)
    );

    pipe_ctrl #(.NSTAGES(5), .FLUSH_CYCLES(1), .MAX_STALL(8), .CNT_W(4)) u_b (
        .clk(clk), .rst(rst), .stallreq(stallreq), .flush_req(flush_req),
        .flush_pc(flush_pc), .stall(b_stall), .flush(b_flush), .new_pc(b_pc),
        .busy(b_busy), .stall_timeout(b_to), .stall_cnt(b_scnt),
        .flush_cnt(b_fcnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        stallreq = '0;
        flush_req = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        stallreq = 5'b11111;
        flush_req = 1'b1;
        flush_pc = 32'h1234_5678;
        tick();
        tick();
        chk("rst_flush", a_flush, 0);
        chk("rst_pc", a_pc, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_to", a_to, 0);
        chk("rst_scnt", a_scnt, 0);
        chk("rst_fcnt", a_fcnt, 0);
        chk("rst_stall", a_stall, 6'b111111);
        chk("rst_b_flush", b_flush, 0);

        rst = 1'b0;
        stallreq = '0;
        flush_req = 1'b0;
        tick();
        chk("idle_stall", a_stall, 0);
        chk("idle_scnt", a_scnt, 0);

        stallreq = 5'b00100;
        #1 chk("map_ex", a_stall, 6'b001111);
        tick();
        stallreq = 5'b00011;
        #1 chk("map_11", a_stall, 6'b000111);
        tick();
        stallreq = 5'b00000;
        #1 chk("map_0", a_stall, 6'b000000);
        tick();
        chk("map_scnt", a_scnt, 2);

        flush_pc = 32'hBFC0_0380;
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        chk("fl1_flush", a_flush, 1);
        chk("fl1_pc", a_pc, 32'hBFC0_0380);
        chk("fl1_busy", a_busy, 1);
        chk("fl1_fcnt", a_fcnt, 1);
        flush_req = 1'b1;
        flush_pc = 32'hDEAD_BEEF;
        tick();
        flush_req = 1'b0;
        chk("fl2_flush", a_flush, 1);
        stallreq = 5'b11111;
        #1 chk("fl2_stall0", a_stall, 0);
        stallreq = 5'b00000;
        tick();
        chk("fl3_flush", a_flush, 1);
        chk("fl3_pc", a_pc, 32'hBFC0_0380);
        tick();
        chk("fl_end_flush", a_flush, 0);
        chk("fl_end_busy", a_busy, 0);
        chk("fl_end_pc", a_pc, 32'hBFC0_0380);
        chk("fl_end_fcnt", a_fcnt, 1);
        tick();
        chk("fl_drop", a_flush, 0);

        do_reset();
        stallreq = 5'b01000;
        flush_req = 1'b1;
        flush_pc = 32'h0000_0100;
        #1 chk("fvs_stall", b_stall, 6'b011111);
        tick();
        flush_req = 1'b0;
        chk("fvs_f_stall", b_stall, 0);
        chk("fvs_f_flush", b_flush, 1);
        tick();
        chk("fvs_back_stall", b_stall, 6'b011111);
        chk("fvs_back_flush", b_flush, 0);
        chk("fvs_scnt", b_scnt, 1);
        stallreq = '0;
        tick();

        do_reset();
        stallreq = 5'b00001;
        for (int i = 0; i < 7; i++) tick();
        stallreq = '0;
        tick();
        chk("to7", a_to, 0);
        chk("to7_scnt", a_scnt, 7);
        stallreq = 5'b00001;
        for (int i = 0; i < 7; i++) tick();
        chk("to8_pre", a_to, 0);
        tick();
        chk("to8", a_to, 1);
        stallreq = '0;
        tick();
        tick();
        chk("to_sticky", a_to, 1);
        do_reset();
        tick();
        chk("to_rst", a_to, 0);

        stallreq = 5'b10000;
        for (int i = 0; i < 14; i++) tick();
        chk("scnt14", a_scnt, 4'hE);
        for (int i = 0; i < 6; i++) tick();
        chk("scnt_sat", a_scnt, 4'hF);
        stallreq = '0;

        do_reset();
        for (int i = 0; i < 20; i++) begin
            flush_req = 1'b1;
            tick();
            flush_req = 1'b0;
            tick();
            if (i == 13) chk("fcnt14", b_fcnt, 4'hE);
        end
        chk("fcnt_sat", b_fcnt, 4'hF);

        do_reset();
        tick();
        flush_req = 1'b1;
        flush_pc = 32'h8000_0000;
        tick();
        flush_req = 1'b0;
        chk("mid_flush", a_flush, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_flush", a_flush, 0);
        chk("mid_rst_busy", a_busy, 0);
        chk("mid_rst_pc", a_pc, 0);
        tick();
        chk("mid_rst_idle", a_flush, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
